// File: rtl/mealy_101_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mealy_101_pkg
// Brief    : State encoding and pattern constant for the 1-0-1 Mealy detector
// Revision : 1.0 - initial release
// ============================================================================
package mealy_101_pkg;

  // Three legal states; 2'b11 is unused and treated as illegal by the FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT1  = 2'b01,
    GOT10 = 2'b10
  } state_t;

  // Detected bit pattern, oldest bit in the MSB.
  localparam logic [2:0] c_PATTERN = 3'b101;

endpackage
`default_nettype wire

// File: rtl/mealy_101_detector.sv
`default_nettype none
// ============================================================================
// Module   : mealy_101_detector
// Brief    : Serial 1-0-1 detector, Mealy output with zero cycles of latency.
//            OVERLAP=1 lets the trailing 1 of a match start the next match.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_101_detector
  import mealy_101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic y
);

  state_t r_state;
  state_t w_next_state;
  logic   w_y;

  // State register; reset drops partial progress immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Mealy output; an illegal encoding falls back to IDLE.
  always_comb begin
    w_next_state = IDLE;
    w_y          = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = x ? GOT1 : IDLE;
      end
      GOT1: begin
        // A run of 1s keeps the detector primed.
        w_next_state = x ? GOT1 : GOT10;
      end
      GOT10: begin
        if (x) begin
          // Gate with reset_n so y is 0 while reset is held.
          w_y          = reset_n;
          w_next_state = OVERLAP ? GOT1 : IDLE;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_y          = 1'b0;
      end
    endcase
  end

  assign y = w_y;

endmodule
`default_nettype wire

// File: tb/tb_mealy_101_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_101_detector
// Brief    : Self-checking bench for mealy_101_detector, both OVERLAP modes
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_101_detector;
  import mealy_101_pkg::*;

  logic clk;
  logic reset_n;
  logic x;
  logic y_ov;
  logic y_no;

  int n_tests;
  int n_fail;

  // Reference history: recent bits since reset (overlap) and bits since the
  // last reset or match (non-overlap, the match bits are not reusable).
  bit q_ov[$];
  bit q_no[$];

  mealy_101_detector #(.OVERLAP(1'b1)) dut_ov (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y_ov)
  );

  mealy_101_detector #(.OVERLAP(1'b0)) dut_no (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y_no)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True when the two remembered bits followed by xb form the pattern.
  function automatic bit hit(input bit q[$], input bit xb);
    logic [2:0] w;
    if (q.size() < 2) return 1'b0;
    w = {q[q.size()-2], q[q.size()-1], xb};
    return (w == c_PATTERN);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] obs);
    n_tests++;
    assert (obs === IDLE) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, IDLE);
    end
  endtask

  // One bit: drive on the falling edge, optionally pulse reset before the
  // rising edge, check y against the model (and constants when use_k),
  // then let the rising edge consume the bit.
  task automatic step(input bit b, input bit rst_pulse, input bit use_k,
                      input bit k_ov, input bit k_no);
    bit e_ov;
    bit e_no;
    @(negedge clk);
    x = b;
    if (rst_pulse) begin
      #1 reset_n = 1'b0;
      #1;
      check("rst_y_ov", y_ov, 1'b0);
      check("rst_y_no", y_no, 1'b0);
      check_state("rst_state_ov", dut_ov.r_state);
      reset_n = 1'b1;
      q_ov.delete();
      q_no.delete();
    end
    #1;
    e_ov = hit(q_ov, b);
    e_no = hit(q_no, b);
    check("model_y_ov", y_ov, e_ov);
    check("model_y_no", y_no, e_no);
    if (use_k) begin
      check("dir_y_ov", y_ov, k_ov);
      check("dir_y_no", y_no, k_no);
    end
    @(posedge clk);
    q_ov.push_back(b);
    if (q_ov.size() > 2) void'(q_ov.pop_front());
    if (e_no) begin
      q_no.delete();
    end else begin
      q_no.push_back(b);
      if (q_no.size() > 2) void'(q_no.pop_front());
    end
  endtask

  // Directed sequences, then a long random stream with reset pulses.
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    x       = 1'b1;

    // Reset held with x=1 across two edges.
    repeat (2) begin
      @(negedge clk);
      #1;
      check("hold_y_ov", y_ov, 1'b0);
      check("hold_y_no", y_no, 1'b0);
      check_state("hold_state_ov", dut_ov.r_state);
      check_state("hold_state_no", dut_no.r_state);
    end

    // 1,0,1 straight after reset.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 1,0,1,0,1 then 0,1: overlap vs non-overlap.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Run of 1s: 1,1,1,0,1.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 1,0,0,1 never matches.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset pulse mid-pattern: 1,0,<reset>1 then 0,1.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Random stream with occasional short reset pulses.
    for (int i = 0; i < 1200; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3), 1'b0,
           1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
